// File: rtl/seq_det_rx_if.sv
// Bundle of the serial receive stream, the compare/count controls and the
// received-word valid/ready handshake for seq_det_rx.
interface seq_det_rx_if #(
    parameter int WIDTH = 10,
    parameter int CNT_W = 16
);
    // serial input stream
    logic             i_serial_data;
    logic             i_bit_valid;
    logic             i_frame_end;
    // compare and counter controls
    logic [WIDTH-1:0] i_pattern;
    logic             i_clear_count;
    // received-word handshake
    logic             i_word_ready;
    logic [WIDTH-1:0] o_word;
    logic             o_word_valid;
    logic             o_match;
    // status
    logic [CNT_W-1:0] o_match_count;
    logic             o_frame_err;
    logic             o_overrun;

    // master: the environment that feeds bits and consumes words
    modport master (
        output i_serial_data, i_bit_valid, i_frame_end, i_pattern,
               i_clear_count, i_word_ready,
        input  o_word, o_word_valid, o_match, o_match_count,
               o_frame_err, o_overrun
    );

    // slave: the receiver itself
    modport slave (
        input  i_serial_data, i_bit_valid, i_frame_end, i_pattern,
               i_clear_count, i_word_ready,
        output o_word, o_word_valid, o_match, o_match_count,
               o_frame_err, o_overrun
    );
endinterface

// File: rtl/seq_det_rx.sv
// LSB-first serial-to-parallel receiver. Frames are delimited by the
// transmitter's done pulse; each completed word is compared against a
// pattern, matches are counted (saturating), and words leave through a
// one-entry valid/ready buffer with overrun and framing-error pulses.
module seq_det_rx #(
    parameter int WIDTH = 10,
    parameter int CNT_W = 16
) (
    input  logic          i_clk,
    input  logic          i_reset,
    seq_det_rx_if.slave   bus
);
    localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BCW-1:0]   LAST_CNT  = BCW'(WIDTH - 1);
    localparam logic [CNT_W-1:0] COUNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    buf_state_t       state_reg, state_next;
    logic [BCW-1:0]   bit_cnt_reg, bit_cnt_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [WIDTH-1:0] word_reg, word_next;
    logic             match_reg, match_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             frame_err_reg, frame_err_next;
    logic             overrun_reg, overrun_next;

    logic [WIDTH-1:0] assembled;
    logic             last_bit;
    logic             complete;
    logic             load;

    // State register for the deserialiser, buffer, counter and status pulses
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg     <= EMPTY;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            word_reg      <= '0;
            match_reg     <= 1'b0;
            count_reg     <= '0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            word_reg      <= word_next;
            match_reg     <= match_next;
            count_reg     <= count_next;
            frame_err_reg <= frame_err_next;
            overrun_reg   <= overrun_next;
        end
    end

    // Next-state logic: bit framing, buffer handshake and match counting
    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        word_next      = word_reg;
        match_next     = match_reg;
        count_next     = count_reg;
        frame_err_next = 1'b0;
        overrun_next   = 1'b0;
        load           = 1'b0;

        // The word as it stands once this cycle's bit is shifted in
        assembled = {bus.i_serial_data, shift_reg[WIDTH-1:1]};
        last_bit  = (bit_cnt_reg == LAST_CNT);
        complete  = bus.i_bit_valid && bus.i_frame_end && last_bit;

        if (bus.i_bit_valid) begin
            if (bus.i_frame_end || last_bit) begin
                // Either a good frame boundary or a misplaced/missing marker:
                // both restart the bit count so we resync on the next bit.
                bit_cnt_next   = '0;
                shift_next     = complete ? assembled : '0;
                frame_err_next = !complete;
            end else begin
                bit_cnt_next = bit_cnt_reg + BCW'(1);
                shift_next   = assembled;
            end
        end

        case (state_reg)
            EMPTY: begin
                if (complete) begin
                    load = 1'b1;
                end
            end
            FULL: begin
                if (complete) begin
                    if (bus.i_word_ready) begin
                        load = 1'b1;
                    end else begin
                        overrun_next = 1'b1;
                    end
                end else if (bus.i_word_ready) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase

        if (load) begin
            state_next = FULL;
            word_next  = assembled;
            match_next = (assembled == bus.i_pattern);
        end

        // Clear wins over a coincident increment; the count never wraps
        if (bus.i_clear_count) begin
            count_next = '0;
        end else if (load && match_next && (count_reg != COUNT_MAX)) begin
            count_next = count_reg + CNT_W'(1);
        end
    end

    assign bus.o_word        = word_reg;
    assign bus.o_word_valid  = (state_reg == FULL);
    assign bus.o_match       = match_reg;
    assign bus.o_match_count = count_reg;
    assign bus.o_frame_err   = frame_err_reg;
    assign bus.o_overrun     = overrun_reg;
endmodule

// File: tb/tb_seq_det_rx.sv
// Directed bench for seq_det_rx (10-bit frames, 2-bit match counter so
// saturation is reachable in a few frames).
module tb_seq_det_rx;
    localparam int WIDTH = 10;
    localparam int CNT_W = 2;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    seq_det_rx_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    seq_det_rx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one clock; outputs are then sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) begin
            $display("vec %0d %s: observed %0h expected %0h ok", vectors, tag, obs, exp);
        end else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Send bits 0..n-1 of w on consecutive cycles; frame marker on bit fe_at
    // (-1 for none); optionally raise clear_count with the last bit.
    task automatic send_bits(input logic [9:0] w, input int n, input int fe_at, input bit clr_last);
        for (int i = 0; i < n; i++) begin
            bus.i_serial_data = w[i];
            bus.i_bit_valid   = 1'b1;
            bus.i_frame_end   = (i == fe_at);
            bus.i_clear_count = clr_last && (i == n - 1);
            tick();
        end
        bus.i_serial_data = 1'b0;
        bus.i_bit_valid   = 1'b0;
        bus.i_frame_end   = 1'b0;
        bus.i_clear_count = 1'b0;
    endtask

    task automatic send_word(input logic [9:0] w);
        send_bits(w, WIDTH, WIDTH - 1, 1'b0);
    endtask

    // Full frame with three idle cycles at random points between bits; the
    // idle cycles carry random data and frame_end, which must be ignored.
    task automatic send_gapped(input logic [9:0] w);
        int gaps [WIDTH];
        for (int i = 0; i < WIDTH; i++) gaps[i] = 0;
        for (int g = 0; g < 3; g++) gaps[$urandom_range(1, WIDTH - 1)]++;
        for (int i = 0; i < WIDTH; i++) begin
            for (int k = 0; k < gaps[i]; k++) begin
                bus.i_serial_data = 1'($urandom_range(0, 1));
                bus.i_bit_valid   = 1'b0;
                bus.i_frame_end   = 1'($urandom_range(0, 1));
                tick();
            end
            bus.i_serial_data = w[i];
            bus.i_bit_valid   = 1'b1;
            bus.i_frame_end   = (i == WIDTH - 1);
            tick();
        end
        bus.i_serial_data = 1'b0;
        bus.i_bit_valid   = 1'b0;
        bus.i_frame_end   = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        bus.i_serial_data = 1'b0;
        bus.i_bit_valid   = 1'b0;
        bus.i_frame_end   = 1'b0;
        bus.i_pattern     = 10'h2D5;
        bus.i_word_ready  = 1'b1;
        bus.i_clear_count = 1'b0;
        tick(); tick(); tick();

        // reset state
        chk("rst_word",  16'(bus.o_word), 16'h000);
        chk("rst_valid", 16'(bus.o_word_valid), 16'h0);
        chk("rst_match", 16'(bus.o_match), 16'h0);
        chk("rst_count", 16'(bus.o_match_count), 16'h0);
        chk("rst_ferr",  16'(bus.o_frame_err), 16'h0);
        chk("rst_ovr",   16'(bus.o_overrun), 16'h0);
        rst = 1'b0;

        // nominal: bits 1,0,1,0,1,0,1,1,0,1 -> 0x2D5
        send_word(10'h2D5);
        chk("nom_word",  16'(bus.o_word), 16'h2D5);
        chk("nom_valid", 16'(bus.o_word_valid), 16'h1);
        chk("nom_match", 16'(bus.o_match), 16'h1);
        tick();
        chk("nom_count", 16'(bus.o_match_count), 16'h1);
        chk("nom_empty", 16'(bus.o_word_valid), 16'h0);

        // backpressure and overrun
        bus.i_word_ready = 1'b0;
        send_word(10'h001);
        chk("bp_word1",  16'(bus.o_word), 16'h001);
        chk("bp_valid1", 16'(bus.o_word_valid), 16'h1);
        chk("bp_match1", 16'(bus.o_match), 16'h0);
        send_word(10'h3FF);
        chk("ovr_pulse", 16'(bus.o_overrun), 16'h1);
        chk("ovr_word",  16'(bus.o_word), 16'h001);
        chk("ovr_valid", 16'(bus.o_word_valid), 16'h1);
        chk("ovr_count", 16'(bus.o_match_count), 16'h1);
        tick();
        chk("ovr_1cyc",  16'(bus.o_overrun), 16'h0);
        chk("ovr_hold",  16'(bus.o_word), 16'h001);
        bus.i_word_ready = 1'b1;
        tick();
        chk("bp_empty",  16'(bus.o_word_valid), 16'h0);
        chk("bp_wkeep",  16'(bus.o_word), 16'h001);

        // framing error: early marker on 4th bit
        send_bits(10'h3C5, 4, 3, 1'b0);
        chk("fe_early",  16'(bus.o_frame_err), 16'h1);
        chk("fe_novld",  16'(bus.o_word_valid), 16'h0);
        tick();
        chk("fe_1cyc",   16'(bus.o_frame_err), 16'h0);
        send_word(10'h155);
        chk("fe_rsync",  16'(bus.o_word), 16'h155);
        chk("fe_rvalid", 16'(bus.o_word_valid), 16'h1);
        chk("fe_noerr",  16'(bus.o_frame_err), 16'h0);
        tick();
        // framing error: 10th bit without marker
        send_bits(10'h0AB, WIDTH, -1, 1'b0);
        chk("fe_miss",   16'(bus.o_frame_err), 16'h1);
        chk("fe_mnovld", 16'(bus.o_word_valid), 16'h0);
        chk("fe_mword",  16'(bus.o_word), 16'h155);
        tick();

        // gapped input
        send_gapped(10'h2AA);
        chk("gap_word",  16'(bus.o_word), 16'h2AA);
        chk("gap_valid", 16'(bus.o_word_valid), 16'h1);
        chk("gap_match", 16'(bus.o_match), 16'h0);
        chk("gap_noerr", 16'(bus.o_frame_err), 16'h0);
        tick();

        // counter saturation and clear priority
        bus.i_clear_count = 1'b1;
        tick();
        bus.i_clear_count = 1'b0;
        chk("cnt_clr", 16'(bus.o_match_count), 16'h0);
        send_word(10'h2D5); chk("cnt_1", 16'(bus.o_match_count), 16'h1);
        send_word(10'h2D5); chk("cnt_2", 16'(bus.o_match_count), 16'h2);
        send_word(10'h2D5); chk("cnt_3", 16'(bus.o_match_count), 16'h3);
        send_word(10'h2D5); chk("cnt_sat4", 16'(bus.o_match_count), 16'h3);
        send_word(10'h2D5); chk("cnt_sat5", 16'(bus.o_match_count), 16'h3);
        send_bits(10'h2D5, WIDTH, WIDTH - 1, 1'b1);
        chk("cnt_clrwin", 16'(bus.o_match_count), 16'h0);
        chk("cnt_6valid", 16'(bus.o_word_valid), 16'h1);
        tick();

        // reset mid-frame with a buffered word present
        bus.i_word_ready = 1'b0;
        send_word(10'h2D5);
        chk("mr_buf", 16'(bus.o_word_valid), 16'h1);
        send_bits(10'h01F, 5, -1, 1'b0);
        rst = 1'b1;
        bus.i_bit_valid = 1'b1;
        bus.i_frame_end = 1'b1;
        tick();
        chk("mr_word",  16'(bus.o_word), 16'h000);
        chk("mr_valid", 16'(bus.o_word_valid), 16'h0);
        chk("mr_match", 16'(bus.o_match), 16'h0);
        chk("mr_count", 16'(bus.o_match_count), 16'h0);
        chk("mr_ferr",  16'(bus.o_frame_err), 16'h0);
        chk("mr_ovr",   16'(bus.o_overrun), 16'h0);
        rst = 1'b0;
        bus.i_bit_valid = 1'b0;
        bus.i_frame_end = 1'b0;
        bus.i_word_ready = 1'b1;
        send_word(10'h0F0);
        chk("mr_fword",  16'(bus.o_word), 16'h0F0);
        chk("mr_fvalid", 16'(bus.o_word_valid), 16'h1);
        chk("mr_fmatch", 16'(bus.o_match), 16'h0);
        chk("mr_fnoerr", 16'(bus.o_frame_err), 16'h0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/seq_det_rx.md
Name: seq_det_rx

Overview:
Serial-in parallel-out receiver for the LSB-first 10-bit serial stream driven by the sequence-detector transmit path. It deserialises one bit per qualified clock and uses the transmitter's done pulse as the frame marker. Each completed word is compared against a programmable pattern, and matches are counted. Received words go out through a one-entry valid/ready buffer with overrun and framing-error reporting.

Parameters:
WIDTH, 10, bits per frame (serial word length)
CNT_W, 16, width of saturating match counter

Ports:
i_clk  in  1  clock, all logic on rising edge
i_reset  in  1  synchronous, active-high reset
i_serial_data  in  1  serial bit, LSB first
i_bit_valid  in  1  qualifies i_serial_data this cycle
i_frame_end  in  1  high with the last (WIDTH-th) bit of a frame (transmitter done pulse)
i_pattern  in  WIDTH  compare pattern, sampled at frame completion
i_word_ready  in  1  downstream accepts o_word this cycle
i_clear_count  in  1  synchronous clear of o_match_count
o_word  out  WIDTH  received word, bit 0 = first bit received
o_word_valid  out  1  o_word/o_match held valid until accepted
o_match  out  1  o_word == i_pattern (as sampled at completion)
o_match_count  out  CNT_W  number of accepted matching words, saturating
o_frame_err  out  1  1-cycle pulse: framing error
o_overrun  out  1  1-cycle pulse: completed word dropped, buffer full

Behaviour:
- Reset: bit_cnt=0, shift_reg=0, all outputs 0. Reset mid-frame discards the partial word and any buffered word. Reset overrides every other input.
- Shifting: only on cycles with i_bit_valid=1. shift_reg <= {i_serial_data, shift_reg[WIDTH-1:1]}, bit_cnt increments. i_frame_end is ignored when i_bit_valid=0.
- Frame completion: i_bit_valid=1, i_frame_end=1 and bit_cnt==WIDTH-1. Completed word = {i_serial_data, shift_reg[WIDTH-1:1]}. bit_cnt returns to 0.
- Framing error, case 1: i_bit_valid=1, i_frame_end=1, bit_cnt!=WIDTH-1 (early marker). Discard the partial word, set bit_cnt=0, pulse o_frame_err next cycle.
- Framing error, case 2: i_bit_valid=1, bit_cnt==WIDTH-1, i_frame_end=0 (missing marker). Same action as case 1. The receiver resyncs on the next bit.
- Buffer states are EMPTY (o_word_valid=0) and FULL (o_word_valid=1).
- Latency: the completed word appears on o_word with o_word_valid=1 on the cycle after its last bit.
- Buffer contents: o_match = (completed word == i_pattern at the completion cycle).
- FULL and i_word_ready=1 with no completion: go to EMPTY. o_word holds its last value.
- FULL, completion and i_word_ready=1 in the same cycle: load the new word, stay FULL, no overrun.
- FULL, completion and i_word_ready=0: drop the new word. o_word/o_match unchanged. Pulse o_overrun next cycle. Match count unchanged.
- o_word/o_match are stable while FULL and not accepted.
- o_match_count increments by 1 when a matching word is loaded into the buffer. It saturates at 2^CNT_W-1, with no wrap.
- i_clear_count has priority: clear and increment in the same cycle gives 0.
- Back-to-back frames with no idle cycles are supported at full rate: one word per WIDTH cycles.

Test Plan:
- Nominal: reset, pattern=0x2D5. Send bits 1,0,1,0,1,0,1,1,0,1 on consecutive cycles with i_frame_end on the 10th, i_word_ready=1 -> next cycle o_word=0x2D5, o_word_valid=1, o_match=1; cycle after o_match_count=1 and buffer EMPTY.
- Backpressure/overrun: i_word_ready=0, send 0x001 then 0x3FF back-to-back -> o_word stays 0x001 and valid. o_overrun pulses one cycle after the second frame's last bit. Raising ready -> EMPTY.
- Framing: i_frame_end on the 4th bit -> o_frame_err pulse, no o_word_valid. Subsequent clean 0x155 frame -> o_word=0x155. A 10th bit without i_frame_end -> o_frame_err, no word.
- Gapped input: 0x2AA with i_bit_valid low for 3 random cycles between bits -> o_word=0x2AA, o_match=0 for pattern 0x2D5.
- Counter: CNT_W=2, five matching frames -> count 1,2,3,3,3. i_clear_count coincident with the sixth match -> 0.
- Reset mid-frame after 5 bits, then full frame 0x0F0 -> o_word=0x0F0, all outputs 0 during reset.
